sd_clock_gen: RTL and testbench

SD_CLOCK_GEN -- requirements
Module: sd_clock_gen

---
 rtl/sd_pkg.sv | 14 +
 rtl/sd_clock_gen_if.sv | 22 ++
 rtl/sd_clk_halfcnt.sv | 35 +++
 rtl/sd_clock_gen.sv | 106 ++++++++++
 tb/tb_sd_clock_gen.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared state encoding and default half-period settings for the SD clock generator.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } sd_state_e;

  localparam int SD_SLOW_HALF = 64;
  localparam int SD_FAST_HALF = 1;
  localparam int SD_CNT_W     = 7;

endpackage

// File: rtl/sd_clock_gen_if.sv
// Control and clock-output bundle between the SD clock generator and its user.
interface sd_clock_gen_if;

  logic ien;
  logic isel_clk;
  logic oclk_sd;
  logic orise;
  logic ofall;
  logic oactive_sel;
  logic orunning;

  modport master (
    output ien, isel_clk,
    input  oclk_sd, orise, ofall, oactive_sel, orunning
  );

  modport slave (
    input  ien, isel_clk,
    output oclk_sd, orise, ofall, oactive_sel, orunning
  );

endinterface

// File: rtl/sd_clk_halfcnt.sv
// Half-period counter: clear wins over enable; tc is high while the count equals term_i.
module sd_clk_halfcnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/sd_clock_gen.sv
// SD card clock generator: registered, glitch-free divided clock with rise/fall strobes.
// The rate is only re-latched when a low phase starts, so every pulse is a full half-period.
module sd_clock_gen
  import sd_pkg::*;
#(
  parameter int SLOW_HALF = SD_SLOW_HALF,
  parameter int FAST_HALF = SD_FAST_HALF,
  parameter int CNT_W     = SD_CNT_W
) (
  input  logic          iclk,
  input  logic          irst,
  sd_clock_gen_if.slave bus
);

  if (SLOW_HALF < 1 || FAST_HALF < 1 ||
      SLOW_HALF > (1 << CNT_W) || FAST_HALF > (1 << CNT_W)) begin : g_bad_half
    $error("sd_clock_gen: half-periods must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_HALF - 1);

  sd_state_e state_q, state_d;
  logic      sel_q, sel_d;
  logic      clk_q, clk_d;
  logic      rise_q, rise_d;
  logic      fall_q, fall_d;
  logic      tc;
  logic      cnt_clr;

  // Counter restarts on every state change and is held at zero while idle.
  assign cnt_clr = (state_q == ST_IDLE) || (state_d != state_q);

  sd_clk_halfcnt #(.CNT_W(CNT_W)) u_halfcnt (
    .clk     (iclk),
    .rst     (irst),
    .clear_i (cnt_clr),
    .en_i    (1'b1),
    .term_i  (sel_q ? FAST_TC : SLOW_TC),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clk_d   = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ien) begin
          state_d = ST_LOW;
          sel_d   = bus.isel_clk;
        end
      end
      ST_LOW: begin
        if (!bus.ien) begin
          state_d = ST_IDLE;
        end else if (tc) begin
          state_d = ST_HIGH;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        clk_d = 1'b1;
        if (tc) begin
          clk_d  = 1'b0;
          fall_d = 1'b1;
          if (bus.ien) begin
            state_d = ST_LOW;
            sel_d   = bus.isel_clk;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.oclk_sd     = clk_q;
  assign bus.orise       = rise_q;
  assign bus.ofall       = fall_q;
  assign bus.oactive_sel = sel_q;
  assign bus.orunning    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_clock_gen.sv
// Directed bench for sd_clock_gen at default rates (slow half 64, fast half 1).
module tb_sd_clock_gen;

  logic iclk = 1'b0;
  logic irst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] obs;

  sd_clock_gen_if bus();

  sd_clock_gen #(.SLOW_HALF(64), .FAST_HALF(1), .CNT_W(7)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  always #5 iclk = ~iclk;

  // {oclk_sd, orise, ofall, oactive_sel, orunning}
  assign obs = {bus.oclk_sd, bus.orise, bus.ofall, bus.oactive_sel, bus.orunning};

  always @(negedge iclk) begin
    checks++;
    if ((bus.orise && bus.ofall) !== 1'b0) begin
      errors++;
      $display("FAIL strobe_overlap: orise=%b ofall=%b, required not both high", bus.orise, bus.ofall);
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (bus.orise) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_fall(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (bus.ofall) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.ien = 1'b0;
    bus.isel_clk = 1'b0;
    irst = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got %b required 00000", obs);
    end
  endtask

  task automatic test_slow();
    int n;
    bus.ien = 1'b1;
    bus.isel_clk = 1'b0;
    irst = 1'b0;
    wait_rise(n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL slow_first_rise: got %0d ticks required 65", n);
    end
    checks++;
    if (obs !== 5'b11001) begin
      errors++;
      $display("FAIL slow_rise_outputs: got %b required 11001", obs);
    end
    wait_fall(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL slow_high_len: got %0d required 64", n);
    end
    wait_rise(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL slow_low_len: got %0d required 64", n);
    end
  endtask

  task automatic test_switch_up();
    repeat (19) tick();
    bus.isel_clk = 1'b1;
    repeat (44) tick();
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL up_last_high: got %b required 10001", obs);
    end
    tick();
    checks++;
    if (obs !== 5'b00111) begin
      errors++;
      $display("FAIL up_fall: got %b required 00111", obs);
    end
  endtask

  task automatic test_fast();
    logic [4:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_v = (i % 2 == 0) ? 5'b11011 : 5'b00111;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL fast_toggle[%0d]: got %b required %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_switch_down();
    int n;
    bus.isel_clk = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b11011) begin
      errors++;
      $display("FAIL down_last_rise: got %b required 11011", obs);
    end
    tick();
    checks++;
    if (obs !== 5'b00101) begin
      errors++;
      $display("FAIL down_fall: got %b required 00101", obs);
    end
    wait_rise(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL down_low_len: got %0d required 64", n);
    end
  endtask

  task automatic test_stop_in_high();
    int n;
    repeat (9) tick();
    bus.ien = 1'b0;
    wait_fall(n);
    checks++;
    if (n !== 55) begin
      errors++;
      $display("FAIL stop_high_fall: got %0d required 55", n);
    end
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL stop_high_idle: got %b required 00100", obs);
    end
    repeat (3) tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL stop_high_parked: got %b required 00000", obs);
    end
    bus.ien = 1'b1;
    wait_rise(n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL restart_low_len: got %0d required 65", n);
    end
  endtask

  task automatic test_stop_in_low();
    int n;
    int seen;
    wait_fall(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL pre_stop_high_len: got %0d required 64", n);
    end
    repeat (4) tick();
    bus.ien = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL stop_low_idle: got %b required 00000", obs);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.oclk_sd || bus.orise || bus.ofall) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL stop_low_quiet: got %0d active cycles required 0", seen);
    end
  endtask

  task automatic test_reset_mid_high();
    int n;
    bus.ien = 1'b1;
    bus.isel_clk = 1'b1;
    wait_rise(n);
    checks++;
    if (n !== 2 || obs !== 5'b11011) begin
      errors++;
      $display("FAIL fast_start: got %0d ticks obs %b required 2 ticks obs 11011", n, obs);
    end
    #2;
    irst = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset: got %b required 00000", obs);
    end
    repeat (2) tick();
    bus.isel_clk = 1'b0;
    irst = 1'b0;
    wait_rise(n);
    checks++;
    if (n !== 65 || obs !== 5'b11001) begin
      errors++;
      $display("FAIL reset_restart: got %0d ticks obs %b required 65 ticks obs 11001", n, obs);
    end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_switch_up();
    test_fast();
    test_switch_down();
    test_stop_in_high();
    test_stop_in_low();
    test_reset_mid_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
